// File: rtl/dtw_path_writer.sv
// DTW path writer: packs backtrace points into a result-SRAM record (header + entries).
// Optional macro DTW_PATH_DEDUP_EN discards repeated {t,r} points within a run.
module dtw_path_writer #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_LEN   = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bt_start,
    input  logic              i_bt_end,
    input  logic [31:0]       i_data,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [31:0]       o_sram_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [6:0]        o_len,
    output logic              o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HDR,
        S_DONE
    } state_t;

`ifdef DTW_PATH_DEDUP_EN
    localparam logic L_DEDUP = 1'b1;
`else
    localparam logic L_DEDUP = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] L_ENT0 = L_BASE + ADDR_W'(1);

    state_t            r_state;
    logic [15:0]       r_score;
    logic [9:0]        r_prev;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic [6:0]        r_len;
    logic              r_ovf;

    logic [9:0]        w_pt;
    logic              w_full;
    logic              w_dup;
    logic              w_acc;
    logic              w_drop;
    logic [ADDR_W-1:0] w_eaddr;

    assign w_pt    = {i_data[28:24], i_data[20:16]};
    assign w_full  = (r_len == 7'(MAX_LEN));
    assign w_dup   = L_DEDUP & (w_pt == r_prev);
    assign w_acc   = i_bt_start & ~w_full & ~w_dup;
    assign w_drop  = i_bt_start & w_full & ~w_dup;
    assign w_eaddr = L_ENT0 + ADDR_W'(r_len);

    function automatic logic [31:0] hdr(input logic ovf, input logic abrt,
                                        input logic [6:0] len, input logic [15:0] sc);
        return {1'b1, ovf, abrt, 6'b0, len, sc};
    endfunction

    // Header goes out directly from RUN when the run's final cycle produced no entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_score <= '0;
            r_prev  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_bt_start) begin
                        r_score <= i_data[15:0];
                        r_prev  <= w_pt;
                        r_ovf   <= 1'b0;
                        r_len   <= 7'd1;
                        r_busy  <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= L_ENT0;
                        r_wdata <= i_data;
                        r_state <= i_bt_end ? S_HDR : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!i_bt_start) begin
                        r_we    <= 1'b1;
                        r_addr  <= L_BASE;
                        r_wdata <= hdr(r_ovf, 1'b1, r_len, r_score);
                        r_state <= S_DONE;
                    end else if (w_acc) begin
                        r_prev  <= w_pt;
                        r_len   <= r_len + 7'd1;
                        r_we    <= 1'b1;
                        r_addr  <= w_eaddr;
                        r_wdata <= i_data;
                        if (i_bt_end)
                            r_state <= S_HDR;
                    end else begin
                        if (w_drop)
                            r_ovf <= 1'b1;
                        if (i_bt_end) begin
                            r_we    <= 1'b1;
                            r_addr  <= L_BASE;
                            r_wdata <= hdr(r_ovf | w_drop, 1'b0, r_len, r_score);
                            r_state <= S_DONE;
                        end
                    end
                end
                S_HDR: begin
                    r_we    <= 1'b1;
                    r_addr  <= L_BASE;
                    r_wdata <= hdr(r_ovf, 1'b0, r_len, r_score);
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_sram_we    = r_we;
    assign o_sram_addr  = r_addr;
    assign o_sram_wdata = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_len        = r_len;
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_dtw_path_writer.sv
// Directed bench for dtw_path_writer: normal, overflow, back-to-back, abort, reset, repeats.
// Expected repeat-run length follows DTW_PATH_DEDUP_EN.
module tb_dtw_path_writer;

    logic        clk;
    logic        rst;
    logic        i_bt_start;
    logic        i_bt_end;
    logic [31:0] i_data;
    logic        o_sram_we;
    logic [9:0]  o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic        o_busy;
    logic        o_done;
    logic [6:0]  o_len;
    logic        o_ovf;

    int n_chk = 0;
    int n_fail = 0;

`ifdef DTW_PATH_DEDUP_EN
    localparam int EXP_REP = 3;
`else
    localparam int EXP_REP = 4;
`endif

    dtw_path_writer dut (
        .clk         (clk),
        .rst         (rst),
        .i_bt_start  (i_bt_start),
        .i_bt_end    (i_bt_end),
        .i_data      (i_data),
        .o_sram_we   (o_sram_we),
        .o_sram_addr (o_sram_addr),
        .o_sram_wdata(o_sram_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_len       (o_len),
        .o_ovf       (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pt(input int t, input int r, input logic [15:0] sc);
        logic [4:0] tt;
        logic [4:0] rr;
        tt = t[4:0];
        rr = r[4:0];
        return {3'b0, tt, 3'b0, rr, sc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic e, input logic [31:0] d);
        i_bt_start = s;
        i_bt_end   = e;
        i_data     = d;
    endtask

    initial begin
        int nw;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_we", {31'b0, o_sram_we}, 32'd0);
        chk("rst_addr", {22'b0, o_sram_addr}, 32'd0);
        chk("rst_wdata", o_sram_wdata, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_len", {25'b0, o_len}, 32'd0);
        chk("rst_ovf", {31'b0, o_ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Five-point run ending with bt_end on the last point
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 4, pt(4 - i, 4 - i, 16'h0123));
            @(negedge clk);
            chk("r5_we", {31'b0, o_sram_we}, 32'd1);
            chk("r5_addr", {22'b0, o_sram_addr}, i + 1);
            chk("r5_data", o_sram_wdata, pt(4 - i, 4 - i, 16'h0123));
            chk("r5_len", {25'b0, o_len}, i + 1);
            chk("r5_busy", {31'b0, o_busy}, 32'd1);
        end
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("r5_hdr_we", {31'b0, o_sram_we}, 32'd1);
        chk("r5_hdr_addr", {22'b0, o_sram_addr}, 32'd0);
        chk("r5_hdr", o_sram_wdata, 32'h80050123);
        chk("r5_hdr_done", {31'b0, o_done}, 32'd0);
        @(negedge clk);
        chk("r5_done", {31'b0, o_done}, 32'd1);
        chk("r5_busy_lo", {31'b0, o_busy}, 32'd0);
        chk("r5_we_lo", {31'b0, o_sram_we}, 32'd0);
        chk("r5_len_fin", {25'b0, o_len}, 32'd5);
        chk("r5_ovf_fin", {31'b0, o_ovf}, 32'd0);
        @(negedge clk);
        chk("r5_done_pulse", {31'b0, o_done}, 32'd0);

        // bt_end without bt_start is ignored while idle
        drive(1'b0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("end_only_we", {31'b0, o_sram_we}, 32'd0);
        chk("end_only_busy", {31'b0, o_busy}, 32'd0);

        // 70-point run: entries stop at 63, end-point dropped so header follows at once
        nw = 0;
        for (int i = 0; i < 70; i++) begin
            drive(1'b1, i == 69, pt(i % 32, (i + 1) % 32, 16'h5A5A));
            @(negedge clk);
            if (i < 69) begin
                if (o_sram_we) nw++;
                chk("ov_we", {31'b0, o_sram_we}, (i < 63) ? 32'd1 : 32'd0);
                if (i < 63)
                    chk("ov_addr", {22'b0, o_sram_addr}, i + 1);
                chk("ov_flag", {31'b0, o_ovf}, (i >= 63) ? 32'd1 : 32'd0);
            end
        end
        chk("ov_nwr", nw, 32'd63);
        chk("ov_hdr_we", {31'b0, o_sram_we}, 32'd1);
        chk("ov_hdr_addr", {22'b0, o_sram_addr}, 32'd0);
        chk("ov_hdr", o_sram_wdata, 32'hC03F5A5A);
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("ov_done", {31'b0, o_done}, 32'd1);
        chk("ov_len", {25'b0, o_len}, 32'd63);
        chk("ov_ovf", {31'b0, o_ovf}, 32'd1);

        // Back-to-back run started during the done pulse
        drive(1'b1, 1'b0, pt(1, 1, 16'h0042));
        @(negedge clk);
        chk("bb_len", {25'b0, o_len}, 32'd1);
        chk("bb_ovf", {31'b0, o_ovf}, 32'd0);
        chk("bb_addr", {22'b0, o_sram_addr}, 32'd1);
        chk("bb_we", {31'b0, o_sram_we}, 32'd1);
        drive(1'b1, 1'b1, pt(0, 0, 16'h0042));
        @(negedge clk);
        chk("bb_addr2", {22'b0, o_sram_addr}, 32'd2);
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("bb_hdr", o_sram_wdata, 32'h80020042);
        chk("bb_hdr_addr", {22'b0, o_sram_addr}, 32'd0);
        // start during DONE is ignored
        drive(1'b1, 1'b0, pt(9, 9, 16'h1111));
        @(negedge clk);
        chk("bb_done", {31'b0, o_done}, 32'd1);
        chk("bb_ign_we", {31'b0, o_sram_we}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // Abort: bt_start falls after three points
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, pt(7 - i, 2, 16'h00FF));
            @(negedge clk);
            chk("ab_addr", {22'b0, o_sram_addr}, i + 1);
            chk("ab_data", o_sram_wdata, pt(7 - i, 2, 16'h00FF));
        end
        drive(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        chk("ab_hdr_we", {31'b0, o_sram_we}, 32'd1);
        chk("ab_hdr_addr", {22'b0, o_sram_addr}, 32'd0);
        chk("ab_hdr", o_sram_wdata, 32'hA00300FF);
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("ab_done", {31'b0, o_done}, 32'd1);
        @(negedge clk);

        // Reset asserted on the third cycle of a run
        drive(1'b1, 1'b0, pt(3, 3, 16'h0A0A));
        @(negedge clk);
        drive(1'b1, 1'b0, pt(2, 2, 16'h0A0A));
        @(negedge clk);
        chk("rr_pre_we", {31'b0, o_sram_we}, 32'd1);
        drive(1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rr_we_async", {31'b0, o_sram_we}, 32'd0);
        chk("rr_busy", {31'b0, o_busy}, 32'd0);
        chk("rr_len", {25'b0, o_len}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nw = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_sram_we) nw++;
        end
        chk("rr_nohdr", nw, 32'd0);
        drive(1'b1, 1'b0, pt(1, 0, 16'h0B0B));
        @(negedge clk);
        chk("rr2_addr1", {22'b0, o_sram_addr}, 32'd1);
        drive(1'b1, 1'b1, pt(0, 0, 16'h0B0B));
        @(negedge clk);
        chk("rr2_addr2", {22'b0, o_sram_addr}, 32'd2);
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rr2_hdr", o_sram_wdata, 32'h80020B0B);
        @(negedge clk);
        chk("rr2_done", {31'b0, o_done}, 32'd1);
        @(negedge clk);

        // Repeated points (2,2),(2,2),(1,1),(0,0)
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 3, pt((i < 2) ? 2 : 3 - i, (i < 2) ? 2 : 3 - i, 16'h0007));
            @(negedge clk);
            if (o_sram_we) nw++;
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("rep_nwr", nw, EXP_REP);
        @(negedge clk);
        chk("rep_hdr_addr", {22'b0, o_sram_addr}, 32'd0);
        chk("rep_hdr", o_sram_wdata, 32'h80000007 | (32'(EXP_REP) << 16));
        @(negedge clk);
        chk("rep_done", {31'b0, o_done}, 32'd1);
        chk("rep_len", {25'b0, o_len}, EXP_REP);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
